// File: rtl/pr_bus_arbiter_if.sv
// pr_bus_arbiter_if: one master-side port of the processor peripheral bus.
// The master drives the request fields and the arbiter returns the completion.
interface pr_bus_arbiter_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wd;
    logic        ready;
    logic        err;
    logic [31:0] rd;

    modport master (
        output req, addr, we, byteen, wd,
        input  ready, err, rd
    );

    modport slave (
        input  req, addr, we, byteen, wd,
        output ready, err, rd
    );
endinterface

// File: rtl/pr_bus_arbiter.sv
// pr_bus_arbiter: two-master arbiter and sequencer for the peripheral bus.
// Grants m0 (CPU memory stage) or m1 (debug/DMA), decodes the latched address
// into the DM, TC0, TC1 or interrupt-register window, performs one access and
// returns a one-cycle ready pulse.
// Optional feature macro: PR_ARB_RR_EN selects round-robin tie-breaking; when
// it is undefined m0 has fixed priority and no pointer register is built.
module pr_bus_arbiter #(
    parameter logic [3:0] TC_CNT_OFF = 4'h8
) (
    input  logic            clk,
    input  logic            reset_n,
    pr_bus_arbiter_if.slave m0,
    pr_bus_arbiter_if.slave m1,
    output logic [31:0]     dm_addr,
    output logic [3:0]      dm_byteen,
    output logic [31:0]     dm_wd,
    input  logic [31:0]     dm_rd,
    output logic [29:0]     tc_addr,
    output logic            tc0_we,
    output logic            tc1_we,
    output logic [31:0]     tc_wd,
    input  logic [31:0]     tc0_rd,
    input  logic [31:0]     tc1_rd,
    output logic            int_we,
    input  logic [31:0]     int_rd,
    output logic            gnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] lat_addr;
    logic        lat_we;
    logic [3:0]  lat_byteen;
    logic [31:0] lat_wd;

    logic        any_req;
    logic        winner;
    logic        grant_now;

    logic        sel_dm;
    logic        sel_tc0;
    logic        sel_tc1;
    logic        sel_int;
    logic        is_cnt_word;
    logic        reg_write_ok;
    logic        acc_err;
    logic        write_ok;
    logic [31:0] resp_rd;

    assign any_req   = m0.req | m1.req;
    assign grant_now = (state == ST_IDLE) && any_req;

`ifdef PR_ARB_RR_EN
    logic rr_ptr;

    // Pick the winner: a lone requester wins, a tie goes to the master not granted last.
    always_comb begin
        winner = m1.req;
        if (m0.req && m1.req) begin
            winner = ~rr_ptr;
        end
    end

    // Remember the last granted master; resets to m1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= 1'b1;
        end else if (grant_now) begin
            rr_ptr <= winner;
        end
    end
`else
    // Pick the winner: m0 wins whenever it requests.
    always_comb begin
        winner = ~m0.req;
    end
`endif

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the winning request and owner at grant time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt        <= 1'b0;
            lat_addr   <= 32'h0;
            lat_we     <= 1'b0;
            lat_byteen <= 4'h0;
            lat_wd     <= 32'h0;
        end else if (grant_now) begin
            gnt <= winner;
            if (winner) begin
                lat_addr   <= m1.addr;
                lat_we     <= m1.we;
                lat_byteen <= m1.byteen;
                lat_wd     <= m1.wd;
            end else begin
                lat_addr   <= m0.addr;
                lat_we     <= m0.we;
                lat_byteen <= m0.byteen;
                lat_wd     <= m0.wd;
            end
        end
    end

    // Decode the latched address into a device window and check the write rules.
    always_comb begin
        sel_dm       = (lat_addr < 32'h0000_3000);
        sel_tc0      = (lat_addr[31:4] == 28'h00007F0) && (lat_addr[3:2] != 2'b11);
        sel_tc1      = (lat_addr[31:4] == 28'h00007F1) && (lat_addr[3:2] != 2'b11);
        sel_int      = (lat_addr[31:2] == 30'h00001FC8);
        is_cnt_word  = (lat_addr[3:2] == TC_CNT_OFF[3:2]);
        reg_write_ok = (lat_byteen == 4'b1111) && !((sel_tc0 || sel_tc1) && is_cnt_word);
        acc_err      = !(sel_dm || sel_tc0 || sel_tc1 || sel_int)
                       || (lat_we && !sel_dm && !reg_write_ok);
        write_ok     = lat_we && !acc_err;
    end

    // Select the response data from the addressed device; errors return zero.
    always_comb begin
        resp_rd = 32'h0;
        if (!acc_err) begin
            if (sel_dm) begin
                resp_rd = dm_rd;
            end else if (sel_tc0) begin
                resp_rd = tc0_rd;
            end else if (sel_tc1) begin
                resp_rd = tc1_rd;
            end else begin
                resp_rd = int_rd;
            end
        end
    end

    // Next-state logic plus the per-state strobes and completion outputs.
    always_comb begin
        state_next = state;
        dm_byteen  = 4'h0;
        tc0_we     = 1'b0;
        tc1_we     = 1'b0;
        int_we     = 1'b0;
        m0.ready   = 1'b0;
        m0.err     = 1'b0;
        m0.rd      = 32'h0;
        m1.ready   = 1'b0;
        m1.err     = 1'b0;
        m1.rd      = 32'h0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (write_ok) begin
                    if (sel_dm) begin
                        dm_byteen = lat_byteen;
                    end else if (sel_tc0) begin
                        tc0_we = 1'b1;
                    end else if (sel_tc1) begin
                        tc1_we = 1'b1;
                    end else begin
                        int_we = 1'b1;
                    end
                end
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (gnt) begin
                    m1.ready = 1'b1;
                    m1.err   = acc_err;
                    m1.rd    = resp_rd;
                end else begin
                    m0.ready = 1'b1;
                    m0.err   = acc_err;
                    m0.rd    = resp_rd;
                end
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign dm_addr = lat_addr;
    assign dm_wd   = lat_wd;
    assign tc_addr = lat_addr[31:2];
    assign tc_wd   = lat_wd;

endmodule
